// File: rtl/imem_loader.sv
// Framed byte-stream loader for the core's instruction memory.
// Collects N little-endian words plus an XOR checksum and releases the core only after a verified image.
module imem_loader #(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR0 = 3'd1,
    S_HDR1 = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [7:0]        n_lo_r;
  logic [15:0]       n_words_r;
  logic [1:0]        byte_cnt_r;
  logic [ADDR_W:0]   word_idx_r;
  logic [23:0]       word_r;
  logic [7:0]        xor_r;
  logic              accept_s;
  logic [15:0]       n_full_s;
  logic              last_word_s;

  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  function automatic logic is_rx_state(input state_t s);
    return (s == S_HDR0) || (s == S_HDR1) || (s == S_DATA) || (s == S_CSUM);
  endfunction

  assign accept_s    = rx_valid & rx_ready;
  assign n_full_s    = {rx_data, n_lo_r};
  // Word index is one bit wider than the address so N == DEPTH_WORDS can terminate.
  assign last_word_s = ((16'(word_idx_r) + 16'd1) == n_words_r);

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: state_s = S_HDR0;
      S_HDR0: begin
        if (accept_s) state_s = S_HDR1;
        else          state_s = S_HDR0;
      end
      S_HDR1: begin
        if (!accept_s)                          state_s = S_HDR1;
        else if (n_full_s > 16'(DEPTH_WORDS))   state_s = S_ERR;
        else if (n_full_s == 16'd0)             state_s = S_CSUM;
        else                                    state_s = S_DATA;
      end
      S_DATA: begin
        if (accept_s && (byte_cnt_r == 2'd3) && last_word_s) state_s = S_CSUM;
        else                                                  state_s = S_DATA;
      end
      S_CSUM: begin
        if (!accept_s)              state_s = S_CSUM;
        else if (rx_data == xor_r)  state_s = S_DONE;
        else                        state_s = S_ERR;
      end
      S_DONE:  state_s = S_DONE;
      S_ERR:   state_s = S_ERR;
      default: state_s = S_ERR;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      n_lo_r     <= 8'd0;
      n_words_r  <= 16'd0;
      byte_cnt_r <= 2'd0;
      word_idx_r <= '0;
      word_r     <= 24'd0;
      xor_r      <= 8'd0;
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      core_hold  <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state_r   <= state_s;
      rx_ready  <= is_rx_state(state_s);
      imem_we   <= 1'b0;
      core_hold <= (state_s != S_DONE);
      load_done <= (state_s == S_DONE);
      load_err  <= (state_s == S_ERR);
      if (accept_s) begin
        case (state_r)
          S_HDR0: n_lo_r <= rx_data;
          S_HDR1: n_words_r <= n_full_s;
          S_DATA: begin
            xor_r      <= csum_update(xor_r, rx_data);
            byte_cnt_r <= byte_cnt_r + 2'd1;
            case (byte_cnt_r)
              2'd0: word_r[7:0]   <= rx_data;
              2'd1: word_r[15:8]  <= rx_data;
              2'd2: word_r[23:16] <= rx_data;
              2'd3: begin
                imem_we    <= 1'b1;
                imem_addr  <= word_idx_r[ADDR_W-1:0];
                imem_wdata <= {rx_data, word_r};
                word_idx_r <= word_idx_r + {{ADDR_W{1'b0}}, 1'b1};
              end
              default: word_r <= word_r;
            endcase
          end
          default: n_lo_r <= n_lo_r;
        endcase
      end else begin
        n_lo_r <= n_lo_r;
      end
    end
  end

endmodule
